mlp_seq_engine: RTL

// Second-generation 2-layer MLP accelerator on the Avalon-MM bus. One time-multiplexed MAC

---
 rtl/mlp_seq_engine.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/mlp_seq_engine.sv
// mlp_seq_engine: 2-layer MLP accelerator on an Avalon-MM slave port.
// A single time-multiplexed MAC evaluates the hidden layer and then the output
// layer from internal weight RAMs. Arithmetic is signed fixed point with FRAC_BITS
// fractional bits. Each layer has optional ReLU, round-half-up and saturation.
// Ports:
//   clk, rst (synchronous, active-low)
//   address/write/writedata/read : register access
//     0 CTRL, 1 INPUT, 2 WEIGHT, 3 OUTSEL/output, 4 CYCLES
//   readdata : registered read data, valid one cycle after read
//   irq      : level interrupt, irq_en & done
module mlp_seq_engine #(
   parameter int unsigned N_INPUTS   = 4,
   parameter int unsigned N_HIDDEN   = 8,
   parameter int unsigned N_OUTPUT   = 4,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 8,
   parameter int unsigned ACC_WIDTH  = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  address,
   input  logic        write,
   input  logic [31:0] writedata,
   input  logic        read,
   output logic [31:0] readdata,
   output logic        irq
);
   localparam int unsigned KMAX = (N_HIDDEN > N_INPUTS) ? N_HIDDEN : N_INPUTS;
   localparam int unsigned JMAX = (N_HIDDEN > N_OUTPUT) ? N_HIDDEN : N_OUTPUT;
   localparam int unsigned KW   = $clog2(KMAX + 1);
   localparam int unsigned JW   = (JMAX > 1) ? $clog2(JMAX) : 1;
   localparam int unsigned XW   = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam int unsigned HW   = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
   localparam int unsigned OW   = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
   localparam int unsigned IW   = $clog2(N_INPUTS + 1);
   localparam int unsigned H1W  = $clog2(N_HIDDEN + 1);
   localparam int unsigned PW   = 2 * DATA_WIDTH;

   localparam logic signed [ACC_WIDTH-1:0] RND  = ACC_WIDTH'(1) <<< (FRAC_BITS - 1);
   localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
   localparam logic signed [ACC_WIDTH-1:0] SMIN = -SMAX - ACC_WIDTH'(1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_L0_MAC = 3'd1;
   localparam logic [2:0] S_L0_WB  = 3'd2;
   localparam logic [2:0] S_L1_MAC = 3'd3;
   localparam logic [2:0] S_L1_WB  = 3'd4;
   localparam logic [2:0] S_FIN    = 3'd5;

   logic [2:0] state, state_nxt;
   logic [KW-1:0] k;
   logic [JW-1:0] j;
   logic signed [ACC_WIDTH-1:0] acc;
   logic signed [DATA_WIDTH-1:0] x    [N_INPUTS];
   logic signed [DATA_WIDTH-1:0] hid  [N_HIDDEN];
   logic signed [DATA_WIDTH-1:0] outv [N_OUTPUT];
   logic signed [DATA_WIDTH-1:0] w0   [N_HIDDEN][N_INPUTS+1];
   logic signed [DATA_WIDTH-1:0] w1   [N_OUTPUT][N_HIDDEN+1];
   logic done, irq_en, relu_hid, relu_out, err;
   logic [15:0] out_sel;
   logic [31:0] cycle_cnt;

   logic busy_c, wr_ctrl_c, wr_in_c, wr_w_c, wr_sel_c, start_c;
   logic in_ok_c, w_ok_c, err_set_c, done_set_c, last_k_c, last_j_c, relu_c;
   logic done_nxt_c, err_nxt_c, irq_en_nxt_c;
   logic [15:0] in_idx_c;
   logic [6:0]  w_row_c;
   logic [7:0]  w_col_c;
   logic signed [DATA_WIDTH-1:0] w_cur_c, a_cur_c, wb_c;
   logic signed [PW-1:0] prod_c;
   logic signed [ACC_WIDTH-1:0] mac_c, rnd_c, shr_c;
   logic [31:0] rd_c;

   // Bus decode, range checks and CTRL next-state
   always_comb begin
      busy_c    = (state != S_IDLE);
      wr_ctrl_c = write && (address == 3'd0);
      wr_in_c   = write && (address == 3'd1);
      wr_w_c    = write && (address == 3'd2);
      wr_sel_c  = write && (address == 3'd3);
      start_c   = wr_ctrl_c && writedata[0] && !busy_c;
      in_idx_c  = writedata[31:16];
      w_row_c   = writedata[30:24];
      w_col_c   = writedata[23:16];
      in_ok_c   = in_idx_c < 16'(N_INPUTS);
      w_ok_c    = writedata[31] ? ((w_row_c < 7'(N_OUTPUT)) && (w_col_c <= 8'(N_HIDDEN)))
                                : ((w_row_c < 7'(N_HIDDEN)) && (w_col_c <= 8'(N_INPUTS)));
      err_set_c = (wr_in_c && (busy_c || !in_ok_c)) ||
                  (wr_w_c && (busy_c || !w_ok_c)) ||
                  (wr_sel_c && busy_c);
      last_k_c  = (state == S_L1_MAC) ? (k == KW'(N_HIDDEN)) : (k == KW'(N_INPUTS));
      last_j_c  = (state == S_L1_WB) ? (j == JW'(N_OUTPUT - 1)) : (j == JW'(N_HIDDEN - 1));
      // done is raised as FIN is entered, so it lands exactly at the end of the last write-back
      done_set_c = (state == S_L1_WB) && last_j_c;

      done_nxt_c = done;
      if (wr_ctrl_c && writedata[1]) done_nxt_c = 1'b0;
      if (start_c) done_nxt_c = 1'b0;
      if (done_set_c) done_nxt_c = 1'b1;
      err_nxt_c = err;
      if (wr_ctrl_c && writedata[6]) err_nxt_c = 1'b0;
      if (err_set_c) err_nxt_c = 1'b1;
      irq_en_nxt_c = wr_ctrl_c ? writedata[2] : irq_en;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start_c) state_nxt = S_L0_MAC;
         S_L0_MAC: if (last_k_c) state_nxt = S_L0_WB;
         S_L0_WB:  state_nxt = last_j_c ? S_L1_MAC : S_L0_MAC;
         S_L1_MAC: if (last_k_c) state_nxt = S_L1_WB;
         S_L1_WB:  state_nxt = last_j_c ? S_FIN : S_L1_MAC;
         S_FIN:    state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // MAC step: k=0 loads the bias scaled to the product's binary point
   always_comb begin
      if (state == S_L1_MAC) begin
         w_cur_c = w1[OW'(j)][H1W'(k)];
         a_cur_c = hid[HW'(k - KW'(1))];
      end else begin
         w_cur_c = w0[HW'(j)][IW'(k)];
         a_cur_c = x[XW'(k - KW'(1))];
      end
      prod_c = PW'(w_cur_c) * PW'(a_cur_c);
      if (k == '0) mac_c = ACC_WIDTH'(w_cur_c) <<< FRAC_BITS;
      else         mac_c = acc + ACC_WIDTH'(prod_c);
   end

   // Write-back: round half up, saturate, optional ReLU
   always_comb begin
      rnd_c = acc + RND;
      shr_c = rnd_c >>> FRAC_BITS;
      if (shr_c > SMAX)      wb_c = DATA_WIDTH'(SMAX);
      else if (shr_c < SMIN) wb_c = DATA_WIDTH'(SMIN);
      else                   wb_c = DATA_WIDTH'(shr_c);
      relu_c = (state == S_L0_WB) ? relu_hid : relu_out;
      if (relu_c && wb_c[DATA_WIDTH-1]) wb_c = '0;
   end

   // Read mux
   always_comb begin
      case (address)
         3'd0:    rd_c = {25'b0, err, busy_c, relu_out, relu_hid, irq_en, done, 1'b0};
         3'd3:    rd_c = (out_sel < 16'(N_OUTPUT)) ? 32'(outv[OW'(out_sel)]) : '0;
         3'd4:    rd_c = cycle_cnt;
         default: rd_c = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Control, datapath and register file
   always_ff @(posedge clk) begin
      if (!rst) begin
         done      <= 1'b0;
         err       <= 1'b0;
         irq_en    <= 1'b0;
         relu_hid  <= 1'b0;
         relu_out  <= 1'b0;
         irq       <= 1'b0;
         readdata  <= '0;
         out_sel   <= '0;
         cycle_cnt <= '0;
         j         <= '0;
         k         <= '0;
         acc       <= '0;
         for (int i = 0; i < int'(N_INPUTS); i++) x[i] <= '0;
         for (int i = 0; i < int'(N_HIDDEN); i++) hid[i] <= '0;
         for (int i = 0; i < int'(N_OUTPUT); i++) outv[i] <= '0;
      end else begin
         done   <= done_nxt_c;
         err    <= err_nxt_c;
         irq_en <= irq_en_nxt_c;
         irq    <= irq_en_nxt_c && done_nxt_c;
         if (wr_ctrl_c) begin
            relu_hid <= writedata[3];
            relu_out <= writedata[4];
         end
         if (read) readdata <= rd_c;
         if (wr_in_c && in_ok_c && !busy_c) x[XW'(in_idx_c)] <= DATA_WIDTH'(writedata[15:0]);
         if (wr_sel_c && !busy_c) out_sel <= writedata[15:0];
         if (start_c) begin
            cycle_cnt <= '0;
            j         <= '0;
            k         <= '0;
         end
         if (state == S_L0_MAC || state == S_L1_MAC) begin
            acc <= mac_c;
            k   <= last_k_c ? '0 : k + KW'(1);
         end
         if (state == S_L0_WB || state == S_L1_WB) j <= last_j_c ? '0 : j + JW'(1);
         if (state == S_L0_WB) hid[HW'(j)] <= wb_c;
         if (state == S_L1_WB) outv[OW'(j)] <= wb_c;
         if (busy_c && state != S_FIN) cycle_cnt <= cycle_cnt + 32'd1;
      end
   end

   // Weight RAMs keep their contents across reset
   always_ff @(posedge clk) begin
      if (rst && wr_w_c && w_ok_c && !busy_c) begin
         if (writedata[31]) w1[OW'(w_row_c)][H1W'(w_col_c)] <= DATA_WIDTH'(writedata[15:0]);
         else               w0[HW'(w_row_c)][IW'(w_col_c)] <= DATA_WIDTH'(writedata[15:0]);
      end
   end

endmodule
